// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage: PC, BOOT/RUN/HALTED FSM, IF/ID register
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   stall          hold PC and IF/ID register
//   branch_taken   redirect PC to branch_target (wins over jump)
//   branch_target  8-bit word address of branch destination
//   jump           redirect PC to jump_target
//   jump_target    8-bit word address of jump destination
//   halt           stop fetching until reset
//   imem_addr      word address to instruction memory (equals PC)
//   imem_rd        instruction word returned combinationally by memory
//   if_instr       IF/ID instruction register (0 when not valid)
//   if_pc_plus1    IF/ID copy of fetch address + 1
//   if_valid       IF/ID register holds a real instruction
//   fetch_count    saturating count of instructions latched into IF/ID
//   halted         high while in HALTED state
module instruction_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    input  logic        jump,
    input  logic [7:0]  jump_target,
    input  logic        halt,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] if_instr,
    output logic [7:0]  if_pc_plus1,
    output logic        if_valid,
    output logic [15:0] fetch_count,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  pc;
    logic [7:0]  pc_inc;
    logic        redirect;
    logic [7:0]  redirect_target;
    logic [15:0] count_next;

    assign imem_addr = pc;

    // 8-bit add wraps 0xFF -> 0x00 naturally
    assign pc_inc = pc + 8'd1;

    // Branch has priority when both redirect sources fire together
    assign redirect        = branch_taken | jump;
    assign redirect_target = branch_taken ? branch_target : jump_target;

    // Counter sticks at all-ones instead of wrapping
    assign count_next = (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            pc          <= 8'h00;
            if_instr    <= 32'h0000_0000;
            if_pc_plus1 <= 8'h00;
            if_valid    <= 1'b0;
            fetch_count <= 16'h0000;
            halted      <= 1'b0;
        end else begin
            case (state)
                // One settling cycle after reset; control inputs ignored
                ST_BOOT: begin
                    state <= ST_RUN;
                end

                ST_RUN: begin
                    if (halt) begin
                        // Halt outranks redirect and stall; leave a NOP bubble
                        state    <= ST_HALTED;
                        halted   <= 1'b1;
                        if_instr <= 32'h0000_0000;
                        if_valid <= 1'b0;
                    end else if (redirect) begin
                        // Redirect outranks stall; squash the IF/ID slot
                        pc       <= redirect_target;
                        if_instr <= 32'h0000_0000;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        pc          <= pc_inc;
                        if_instr    <= imem_rd;
                        if_pc_plus1 <= pc_inc;
                        if_valid    <= 1'b1;
                        fetch_count <= count_next;
                    end
                end

                // Frozen until reset
                ST_HALTED: begin
                    halted <= 1'b1;
                end

                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        jump;
    logic [7:0]  jump_target;
    logic        halt;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] if_instr;
    logic [7:0]  if_pc_plus1;
    logic        if_valid;
    logic [15:0] fetch_count;
    logic        halted;

    logic [31:0] mem [256];

    int n_checks;
    int n_fail;

    typedef struct {
        logic        stall;
        logic        br;
        logic [7:0]  bt;
        logic        jp;
        logic [7:0]  jt;
        logic        hl;
        logic [7:0]  e_addr;
        logic [31:0] e_instr;
        logic [7:0]  e_pc1;
        logic        e_valid;
        logic [15:0] e_cnt;
        logic        e_halted;
    } vec_t;

    vec_t vecs [16];
    vec_t sb_q [$];

    instruction_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .if_instr      (if_instr),
        .if_pc_plus1   (if_pc_plus1),
        .if_valid      (if_valid),
        .fetch_count   (fetch_count),
        .halted        (halted)
    );

    assign imem_rd = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        check({tag, " imem_addr"},   {24'h0, imem_addr},   {24'h0, e.e_addr});
        check({tag, " if_instr"},    if_instr,             e.e_instr);
        check({tag, " if_pc_plus1"}, {24'h0, if_pc_plus1}, {24'h0, e.e_pc1});
        check({tag, " if_valid"},    {31'h0, if_valid},    {31'h0, e.e_valid});
        check({tag, " fetch_count"}, {16'h0, fetch_count}, {16'h0, e.e_cnt});
        check({tag, " halted"},      {31'h0, halted},      {31'h0, e.e_halted});
    endtask

    function automatic vec_t mk(input logic s, input logic br, input logic [7:0] bt,
                                input logic jp, input logic [7:0] jt, input logic hl,
                                input logic [7:0] ea, input logic [31:0] ei, input logic [7:0] ep,
                                input logic ev, input logic [15:0] ec, input logic eh);
        vec_t v;
        v.stall = s; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt; v.hl = hl;
        v.e_addr = ea; v.e_instr = ei; v.e_pc1 = ep; v.e_valid = ev; v.e_cnt = ec; v.e_halted = eh;
        return v;
    endfunction

    vec_t rst_exp;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int a = 0; a < 256; a++) mem[a] = 32'hA000_0000 | a;
        mem[0] = 32'h2001_0003;
        mem[1] = 32'h2002_0009;
        mem[2] = 32'h0022_1020;

        rst_exp = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 32'h0, 8'h00, 0, 16'h0, 0);

        //         stall br bt    jp jt    hl  addr   instr          pc1    v  cnt  h
        vecs[0]  = mk(1, 1, 8'h33, 1, 8'h77, 1, 8'h00, 32'h0,         8'h00, 0, 16'd0, 0); // BOOT ignores all
        vecs[1]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h01, 32'h2001_0003, 8'h01, 1, 16'd1, 0);
        vecs[2]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h02, 32'h2002_0009, 8'h02, 1, 16'd2, 0);
        vecs[3]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h02, 32'h2002_0009, 8'h02, 1, 16'd2, 0);
        vecs[4]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h02, 32'h2002_0009, 8'h02, 1, 16'd2, 0);
        vecs[5]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h02, 32'h2002_0009, 8'h02, 1, 16'd2, 0);
        vecs[6]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h03, 32'h0022_1020, 8'h03, 1, 16'd3, 0);
        vecs[7]  = mk(1, 1, 8'h40, 1, 8'h80, 0, 8'h40, 32'h0,         8'h03, 0, 16'd3, 0); // branch beats jump and stall
        vecs[8]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h41, 32'hA000_0040, 8'h41, 1, 16'd4, 0);
        vecs[9]  = mk(0, 0, 8'h00, 1, 8'hFF, 0, 8'hFF, 32'h0,         8'h41, 0, 16'd4, 0);
        vecs[10] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 32'hA000_00FF, 8'h00, 1, 16'd5, 0); // wrap
        vecs[11] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h01, 32'h2001_0003, 8'h01, 1, 16'd6, 0);
        vecs[12] = mk(0, 0, 8'h00, 1, 8'h05, 0, 8'h05, 32'h0,         8'h01, 0, 16'd6, 0);
        vecs[13] = mk(1, 1, 8'h40, 0, 8'h00, 1, 8'h05, 32'h0,         8'h01, 0, 16'd6, 1); // halt wins
        vecs[14] = mk(0, 1, 8'h20, 1, 8'h30, 0, 8'h05, 32'h0,         8'h01, 0, 16'd6, 1);
        vecs[15] = mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h05, 32'h0,         8'h01, 0, 16'd6, 1);

        rst_n = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        jump = 1'b0; jump_target = 8'h00; halt = 1'b0;

        repeat (2) @(negedge clk);
        check_all("reset", rst_exp);

        // Table: drive on negedge, push expectation, pop and compare after posedge
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst_n         = 1'b1;
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].bt;
            jump          = vecs[i].jp;
            jump_target   = vecs[i].jt;
            halt          = vecs[i].hl;
            sb_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                check_all($sformatf("vec%0d", i), sb_q.pop_front());
            end
        end

        // Reset out of HALTED, then restart from address 0
        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; halt = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all("rst_halted", rst_exp);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("boot_edge", rst_exp);
        @(posedge clk); #1;
        check_all("first_fetch", mk(0, 0, 0, 0, 0, 0, 8'h01, 32'h2001_0003, 8'h01, 1, 16'd1, 0));
        @(posedge clk); #1;
        check_all("second_fetch", mk(0, 0, 0, 0, 0, 0, 8'h02, 32'h2002_0009, 8'h02, 1, 16'd2, 0));

        // Asynchronous reset between edges while stalled
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", rst_exp);
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;

        // Saturation of fetch_count over a long free run
        @(posedge clk);
        repeat (65534) @(posedge clk);
        #1;
        check("cnt_fffe", {16'h0, fetch_count}, 32'h0000_FFFE);
        @(posedge clk); #1;
        check("cnt_ffff", {16'h0, fetch_count}, 32'h0000_FFFF);
        check("pc1_at_ffff", {24'h0, if_pc_plus1}, 32'h0000_00FF);
        repeat (3) @(posedge clk);
        #1;
        check("cnt_saturated", {16'h0, fetch_count}, 32'h0000_FFFF);
        check("pc1_after_sat", {24'h0, if_pc_plus1}, 32'h0000_0002);
        check("instr_after_sat", if_instr, 32'h2002_0009);
        check("valid_after_sat", {31'h0, if_valid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
